// File: rtl/regs_operand_fetch_pkg.sv
// Shared GPR-file constants and operand-selection helpers for the operand fetch slice.
package regs_operand_fetch_pkg;

  localparam int unsigned GPR_XLEN = 64;
  localparam int unsigned GPR_AW   = 5;

  typedef logic [GPR_AW-1:0] gpr_idx_t;

  // Where a delivered operand comes from.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_FWD  = 2'd1,
    SRC_GPR  = 2'd2
  } opnd_src_e;

  // Unused or absent operands read as zero; captured writeback data
  // overrides the GPR read port, which may hold pre-write data.
  function automatic opnd_src_e opnd_src(input logic valid, input logic used, input logic fwd);
    if (!valid || !used) begin
      return SRC_ZERO;
    end else if (fwd) begin
      return SRC_FWD;
    end else begin
      return SRC_GPR;
    end
  endfunction

endpackage

// File: rtl/regs_operand_fetch_if.sv
// Decode request, GPR read ports, writeback snoop and execute handshake bundle.
interface regs_operand_fetch_if #(
  parameter int unsigned TAG_W = 32,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned AW    = 5
);

  // decode side
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_ra;
  logic [AW-1:0]    in_rb;
  logic             in_use_a;
  logic             in_use_b;
  logic [TAG_W-1:0] in_tag;

  // GPR read ports
  logic             readEn0;
  logic [AW-1:0]    readAddr0;
  logic [XLEN-1:0]  readData0;
  logic             readEn1;
  logic [AW-1:0]    readAddr1;
  logic [XLEN-1:0]  readData1;

  // GPR write port snoop
  logic             wb0_en;
  logic [AW-1:0]    wb0_addr;
  logic [XLEN-1:0]  wb0_data;
  logic             wb1_en;
  logic [AW-1:0]    wb1_addr;
  logic [XLEN-1:0]  wb1_data;

  // execute side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_a;
  logic [XLEN-1:0]  out_b;
  logic [TAG_W-1:0] out_tag;

  // Environment view: decode, GPR file and execute.
  modport master (
    output in_valid, in_ra, in_rb, in_use_a, in_use_b, in_tag,
    input  in_ready,
    input  readEn0, readAddr0, readEn1, readAddr1,
    output readData0, readData1,
    output wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
    input  out_valid, out_a, out_b, out_tag,
    output out_ready
  );

  // Operand fetch block view.
  modport slave (
    input  in_valid, in_ra, in_rb, in_use_a, in_use_b, in_tag,
    output in_ready,
    output readEn0, readAddr0, readEn1, readAddr1,
    input  readData0, readData1,
    input  wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
    output out_valid, out_a, out_b, out_tag,
    input  out_ready
  );

endinterface

// File: rtl/regs_fwd_match.sv
// Writeback snoop comparator: reports whether either GPR write port targets addr.
module regs_fwd_match #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic            hit,
  output logic [XLEN-1:0] data
);

  // Port 1 is written last by the GPR file, so it takes priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (wb1_en && (wb1_addr == addr)) begin
      hit  = 1'b1;
      data = wb1_data;
    end else if (wb0_en && (wb0_addr == addr)) begin
      hit  = 1'b1;
      data = wb0_data;
    end
  end

endmodule

// File: rtl/regs_operand_fetch.sv
// Operand fetch: issues GPR reads for decode requests, hides the registered
// read latency in one holding stage and forwards writebacks that the GPR
// read data would otherwise miss.
module regs_operand_fetch
  import regs_operand_fetch_pkg::*;
#(
  parameter int unsigned TAG_W = 32,
  parameter int unsigned XLEN  = GPR_XLEN,
  parameter int unsigned AW    = GPR_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regs_operand_fetch_if.slave  bus
);

  logic             accept;
  logic             in_ready;

  logic             s_valid;
  logic             s_use_a;
  logic             s_use_b;
  logic             s_fwd_a;
  logic             s_fwd_b;
  logic [XLEN-1:0]  s_fwd_data_a;
  logic [XLEN-1:0]  s_fwd_data_b;
  logic [AW-1:0]    s_ra;
  logic [AW-1:0]    s_rb;
  logic [TAG_W-1:0] s_tag;

  logic [AW-1:0]    match_addr_a;
  logic [AW-1:0]    match_addr_b;
  logic             hit_a;
  logic             hit_b;
  logic [XLEN-1:0]  hit_data_a;
  logic [XLEN-1:0]  hit_data_b;

  opnd_src_e        src_a;
  opnd_src_e        src_b;

  // Handshake and GPR read-port drive; reads fire only on accept so the GPR
  // output register holds the operand while the stage is stalled.
  always_comb begin
    in_ready = !s_valid || bus.out_ready;
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.readEn0   = accept && bus.in_use_a;
  assign bus.readAddr0 = bus.in_ra;
  assign bus.readEn1   = accept && bus.in_use_b;
  assign bus.readAddr1 = bus.in_rb;

  // One comparator per operand serves both the accept check (incoming
  // address) and the hold snoop (captured address), selected by accept.
  always_comb begin
    match_addr_a = accept ? bus.in_ra : s_ra;
    match_addr_b = accept ? bus.in_rb : s_rb;
  end

  regs_fwd_match #(.XLEN(XLEN), .AW(AW)) u_match_a (
    .addr     (match_addr_a),
    .wb0_en   (bus.wb0_en),
    .wb0_addr (bus.wb0_addr),
    .wb0_data (bus.wb0_data),
    .wb1_en   (bus.wb1_en),
    .wb1_addr (bus.wb1_addr),
    .wb1_data (bus.wb1_data),
    .hit      (hit_a),
    .data     (hit_data_a)
  );

  regs_fwd_match #(.XLEN(XLEN), .AW(AW)) u_match_b (
    .addr     (match_addr_b),
    .wb0_en   (bus.wb0_en),
    .wb0_addr (bus.wb0_addr),
    .wb0_data (bus.wb0_data),
    .wb1_en   (bus.wb1_en),
    .wb1_addr (bus.wb1_addr),
    .wb1_data (bus.wb1_data),
    .hit      (hit_b),
    .data     (hit_data_b)
  );

  // Holding stage: reload on accept, drain on fire, otherwise snoop writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid      <= 1'b0;
      s_use_a      <= 1'b0;
      s_use_b      <= 1'b0;
      s_fwd_a      <= 1'b0;
      s_fwd_b      <= 1'b0;
      s_fwd_data_a <= '0;
      s_fwd_data_b <= '0;
      s_ra         <= '0;
      s_rb         <= '0;
      s_tag        <= '0;
    end else if (accept) begin
      s_valid <= 1'b1;
      s_use_a <= bus.in_use_a;
      s_use_b <= bus.in_use_b;
      s_ra    <= bus.in_ra;
      s_rb    <= bus.in_rb;
      s_tag   <= bus.in_tag;
      s_fwd_a <= hit_a;
      s_fwd_b <= hit_b;
      if (hit_a) begin
        s_fwd_data_a <= hit_data_a;
      end
      if (hit_b) begin
        s_fwd_data_b <= hit_data_b;
      end
    end else if (s_valid) begin
      if (bus.out_ready) begin
        s_valid <= 1'b0;
      end
      if (s_use_a && hit_a) begin
        s_fwd_a      <= 1'b1;
        s_fwd_data_a <= hit_data_a;
      end
      if (s_use_b && hit_b) begin
        s_fwd_b      <= 1'b1;
        s_fwd_data_b <= hit_data_b;
      end
    end
  end

  // Operand delivery mux.
  always_comb begin
    src_a = opnd_src(s_valid, s_use_a, s_fwd_a);
    src_b = opnd_src(s_valid, s_use_b, s_fwd_b);
    case (src_a)
      SRC_FWD: bus.out_a = s_fwd_data_a;
      SRC_GPR: bus.out_a = bus.readData0;
      default: bus.out_a = '0;
    endcase
    case (src_b)
      SRC_FWD: bus.out_b = s_fwd_data_b;
      SRC_GPR: bus.out_b = bus.readData1;
      default: bus.out_b = '0;
    endcase
  end

  assign bus.out_valid = s_valid;
  assign bus.out_tag   = s_valid ? s_tag : '0;

endmodule
